// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with built-in test patterns and an external pixel request port.
// Scan counters feed two register stages so sync, blank and colour reach the pins together.
module vga_timing_gen #(
    parameter int unsigned HDISP      = 640,
    parameter int unsigned HFP        = 16,
    parameter int unsigned HPULSE     = 96,
    parameter int unsigned HBP        = 48,
    parameter int unsigned VDISP      = 480,
    parameter int unsigned VFP        = 10,
    parameter int unsigned VPULSE     = 2,
    parameter int unsigned VBP        = 33,
    parameter logic        HS_POL     = 1'b0,
    parameter logic        VS_POL     = 1'b0,
    parameter int unsigned CHECK_LOG2 = 5,
    localparam int unsigned HTOTAL    = HDISP + HFP + HPULSE + HBP,
    localparam int unsigned VTOTAL    = VDISP + VFP + VPULSE + VBP,
    localparam int unsigned XW        = $clog2(HTOTAL),
    localparam int unsigned YW        = $clog2(VTOTAL)
) (
    input  logic          CLK,
    input  logic          rst_async,
    input  logic          ENABLE,
    input  logic [1:0]    PAT_SEL,
    input  logic [29:0]   PIX_RGB,
    output logic          PIX_REQ,
    output logic [XW-1:0] PIX_X,
    output logic [YW-1:0] PIX_Y,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK,
    output logic          VGA_SYNC,
    output logic [9:0]    VGA_R,
    output logic [9:0]    VGA_G,
    output logic [9:0]    VGA_B,
    output logic          FRAME_START,
    output logic [15:0]   FRAME_CNT
);
    localparam int unsigned SEG  = HDISP / 8;
    localparam int unsigned SW   = (SEG > 1) ? $clog2(SEG) : 1;
    localparam logic [9:0]  FULL = 10'h3FF;

    if ((HDISP % 8) != 0 || HDISP == 0 || HFP == 0 || HPULSE == 0 || HBP == 0 ||
        VDISP == 0 || VFP == 0 || VPULSE == 0 || VBP == 0 ||
        CHECK_LOG2 >= XW || CHECK_LOG2 >= YW) begin : g_param_err
        $error("vga_timing_gen: HDISP must be a nonzero multiple of 8 and all timings nonzero");
    end

    logic [XW-1:0] hcnt;
    logic [YW-1:0] vcnt;
    logic [SW-1:0] seg_px;
    logic [2:0]    seg_idx;
    logic          wrap_q;
    logic [1:0]    mode_q;

    logic          h_last, v_last, origin, act, hs_on, vs_on;
    logic [1:0]    mode_eff;
    logic [9:0]    pat_r, pat_g, pat_b;

    assign h_last   = (hcnt == XW'(HTOTAL - 1));
    assign v_last   = (vcnt == YW'(VTOTAL - 1));
    assign origin   = (hcnt == '0) && (vcnt == '0);
    assign act      = (hcnt < XW'(HDISP)) && (vcnt < YW'(VDISP));
    assign hs_on    = (hcnt >= XW'(HDISP + HFP)) && (hcnt < XW'(HDISP + HFP + HPULSE));
    assign vs_on    = (vcnt >= YW'(VDISP + VFP)) && (vcnt < YW'(VDISP + VFP + VPULSE));
    assign mode_eff = origin ? PAT_SEL : mode_q;
    assign VGA_SYNC = 1'b0;

    // Stage 0: scan counters; seg_px/seg_idx track hcnt / (HDISP/8) without a divider
    always_ff @(posedge CLK or posedge rst_async) begin
        if (rst_async) begin
            hcnt    <= '0;
            vcnt    <= '0;
            seg_px  <= '0;
            seg_idx <= '0;
            wrap_q  <= 1'b0;
        end else if (!ENABLE) begin
            hcnt    <= '0;
            vcnt    <= '0;
            seg_px  <= '0;
            seg_idx <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= h_last && v_last;
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + YW'(1);
            end else begin
                hcnt <= hcnt + XW'(1);
            end
            if (h_last) begin
                seg_px  <= '0;
                seg_idx <= '0;
            end else if (hcnt < XW'(HDISP)) begin
                if (seg_px == SW'(SEG - 1)) begin
                    seg_px  <= '0;
                    seg_idx <= seg_idx + 3'd1;
                end else begin
                    seg_px <= seg_px + SW'(1);
                end
            end
        end
    end

    // Pattern mode is sampled only at the frame origin
    always_ff @(posedge CLK or posedge rst_async) begin
        if (rst_async) begin
            mode_q <= 2'd0;
        end else if (origin) begin
            mode_q <= PAT_SEL;
        end
    end

    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        case (mode_eff)
            2'd0: begin
                pat_r = {10{~seg_idx[1]}};
                pat_g = {10{~seg_idx[2]}};
                pat_b = {10{~seg_idx[0]}};
            end
            2'd1: begin
                if (hcnt[CHECK_LOG2] ^ vcnt[CHECK_LOG2]) begin
                    pat_r = FULL;
                    pat_g = FULL;
                    pat_b = FULL;
                end
            end
            2'd2: begin
                pat_r = 10'(hcnt);
                pat_g = 10'(hcnt);
                pat_b = 10'(hcnt);
            end
            default: ;
        endcase
    end

    logic       hs1, vs1, blank1, fs1, inc1;
    logic [9:0] r1, g1, b1;

    // Stage 1: request port, pattern colour, sync/blank
    always_ff @(posedge CLK or posedge rst_async) begin
        if (rst_async || !ENABLE) begin
            PIX_X   <= '0;
            PIX_Y   <= '0;
            PIX_REQ <= 1'b0;
            r1      <= '0;
            g1      <= '0;
            b1      <= '0;
            hs1     <= ~HS_POL;
            vs1     <= ~VS_POL;
            blank1  <= 1'b0;
            fs1     <= 1'b0;
            inc1    <= 1'b0;
        end else begin
            PIX_X   <= hcnt;
            PIX_Y   <= vcnt;
            PIX_REQ <= act && (mode_eff == 2'd3);
            r1      <= act ? pat_r : '0;
            g1      <= act ? pat_g : '0;
            b1      <= act ? pat_b : '0;
            hs1     <= hs_on ? HS_POL : ~HS_POL;
            vs1     <= vs_on ? VS_POL : ~VS_POL;
            blank1  <= act;
            fs1     <= origin;
            inc1    <= wrap_q;
        end
    end

    // Stage 2: pins; external pixel captured in the cycle after its request
    always_ff @(posedge CLK or posedge rst_async) begin
        if (rst_async) begin
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK   <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            FRAME_START <= 1'b0;
            FRAME_CNT   <= '0;
        end else if (!ENABLE) begin
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK   <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            FRAME_START <= 1'b0;
        end else begin
            VGA_HS      <= hs1;
            VGA_VS      <= vs1;
            VGA_BLANK   <= blank1;
            {VGA_R, VGA_G, VGA_B} <= PIX_REQ ? PIX_RGB : {r1, g1, b1};
            FRAME_START <= fs1;
            FRAME_CNT   <= FRAME_CNT + 16'(inc1);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster: a scan-position reference model
// predicts every cycle's outputs, a separate monitor compares them against the pins.
module tb_vga_timing_gen;
    localparam int unsigned HDISP  = 24;
    localparam int unsigned HFP    = 2;
    localparam int unsigned HPULSE = 3;
    localparam int unsigned HBP    = 2;
    localparam int unsigned VDISP  = 6;
    localparam int unsigned VFP    = 1;
    localparam int unsigned VPULSE = 2;
    localparam int unsigned VBP    = 1;
    localparam int unsigned CL     = 2;
    localparam logic        HS_POL = 1'b0;
    localparam logic        VS_POL = 1'b1;
    localparam int unsigned HT     = HDISP + HFP + HPULSE + HBP;
    localparam int unsigned VT     = VDISP + VFP + VPULSE + VBP;
    localparam int unsigned FT     = HT * VT;
    localparam int unsigned XW     = $clog2(HT);
    localparam int unsigned YW     = $clog2(VT);
    localparam logic [2:0]  BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                         3'b101, 3'b100, 3'b001, 3'b000};

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          blank;
        logic          sync;
        logic [9:0]    r;
        logic [9:0]    g;
        logic [9:0]    b;
        logic          fs;
        logic [15:0]   fcnt;
        logic          req;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } obs_t;

    logic          CLK = 1'b0;
    logic          rst_async = 1'b1;
    logic          ENABLE = 1'b0;
    logic [1:0]    PAT_SEL = 2'd0;
    logic [29:0]   PIX_RGB;
    logic          PIX_REQ;
    logic [XW-1:0] PIX_X;
    logic [YW-1:0] PIX_Y;
    logic          VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, FRAME_START;
    logic [9:0]    VGA_R, VGA_G, VGA_B;
    logic [15:0]   FRAME_CNT;

    vga_timing_gen #(
        .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CHECK_LOG2(CL)
    ) dut (
        .CLK(CLK), .rst_async(rst_async), .ENABLE(ENABLE), .PAT_SEL(PAT_SEL),
        .PIX_RGB(PIX_RGB), .PIX_REQ(PIX_REQ), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .FRAME_START(FRAME_START), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    // External pixel source: colour is a fixed function of the requested coordinate
    function automatic logic [29:0] echo(int unsigned x, int unsigned y);
        return {10'(x), 10'(y), 10'((x * 5 + y * 11) % 1024)};
    endfunction

    assign PIX_RGB = echo(int'(PIX_X), int'(PIX_Y));

    function automatic logic [29:0] pattern(int unsigned h, int unsigned v, logic [1:0] m);
        logic [2:0] c;
        logic [9:0] gr;
        case (m)
            2'd0: begin
                c = BARS[h * 8 / HDISP];
                return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
            end
            2'd1: return ((((h >> CL) ^ (v >> CL)) & 1) != 0) ? {30{1'b1}} : 30'h0;
            2'd2: begin
                gr = 10'(h % 1024);
                return {gr, gr, gr};
            end
            default: return 30'h0;
        endcase
    endfunction

    function automatic obs_t inactive();
        obs_t o;
        o    = '0;
        o.hs = ~HS_POL;
        o.vs = ~VS_POL;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("hs=%0b vs=%0b blank=%0b sync=%0b rgb=%h/%h/%h fs=%0b cnt=%0d req=%0b x=%0d y=%0d",
                         o.hs, o.vs, o.blank, o.sync, o.r, o.g, o.b, o.fs, o.fcnt, o.req, o.x, o.y);
    endfunction

    // Reference model state: scan position since the scan (re)started
    obs_t        exp_q[$];
    obs_t        s1, s2;
    logic        inc1 = 1'b0;
    int unsigned pos = 0;
    int unsigned m_fcnt = 0;
    logic [1:0]  m_mode = 2'd0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;

    task automatic step(input bit rst, input bit en, input logic [1:0] ps);
        obs_t        n1, n2, e;
        int unsigned h, v;
        bit          act, new_inc;
        @(negedge CLK);
        rst_async = rst;
        ENABLE    = en;
        PAT_SEL   = ps;
        if (rst) begin
            pos    = 0;
            m_fcnt = 0;
            m_mode = 2'd0;
            s1     = inactive();
            s2     = inactive();
            inc1   = 1'b0;
        end else begin
            n2 = inactive();
            if (en) begin
                n2.hs    = s1.hs;
                n2.vs    = s1.vs;
                n2.blank = s1.blank;
                n2.fs    = s1.fs;
                {n2.r, n2.g, n2.b} = s1.req ? echo(int'(s1.x), int'(s1.y)) : {s1.r, s1.g, s1.b};
                if (inc1) m_fcnt = (m_fcnt + 1) % 65536;
            end
            n1      = inactive();
            new_inc = 1'b0;
            if (en) begin
                h = pos % HT;
                v = (pos / HT) % VT;
                if (pos % FT == 0) m_mode = ps;
                act      = (h < HDISP) && (v < VDISP);
                n1.x     = XW'(h);
                n1.y     = YW'(v);
                n1.blank = act;
                n1.req   = act && (m_mode == 2'd3);
                n1.hs    = (h >= HDISP + HFP && h < HDISP + HFP + HPULSE) ? HS_POL : ~HS_POL;
                n1.vs    = (v >= VDISP + VFP && v < VDISP + VFP + VPULSE) ? VS_POL : ~VS_POL;
                n1.fs    = (pos % FT == 0);
                new_inc  = (pos > 0) && (pos % FT == 0);
                if (act && m_mode != 2'd3) {n1.r, n1.g, n1.b} = pattern(h, v, m_mode);
                pos++;
            end else begin
                pos = 0;
            end
            s1   = n1;
            s2   = n2;
            inc1 = new_inc;
        end
        e      = s2;
        e.sync = 1'b0;
        e.fcnt = 16'(m_fcnt);
        e.req  = s1.req;
        e.x    = s1.x;
        e.y    = s1.y;
        exp_q.push_back(e);
    endtask

    task automatic run(input int unsigned n, input logic [1:0] ps);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b1, ps);
    endtask

    // Monitor: one expectation per clock, sampled just after the active edge
    initial begin
        obs_t a, e;
        @(negedge CLK);
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            a.hs = VGA_HS;       a.vs = VGA_VS;       a.blank = VGA_BLANK; a.sync = VGA_SYNC;
            a.r = VGA_R;         a.g = VGA_G;         a.b = VGA_B;         a.fs = FRAME_START;
            a.fcnt = FRAME_CNT;  a.req = PIX_REQ;     a.x = PIX_X;         a.y = PIX_Y;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cyc %0d scoreboard: no expectation queued, got %s", cyc, fmt(a));
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cyc %0d outputs: got %s | want %s", cyc, fmt(a), fmt(e));
                end
            end
        end
    end

    initial begin
        logic [1:0]  ps;
        int unsigned r;
        s1 = inactive();
        s2 = inactive();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0);
        // Each mode requested mid-frame, taking effect at the next frame
        run(FT / 2, 2'd0);
        run(FT, 2'd1);
        run(FT, 2'd2);
        run(FT, 2'd3);
        run(FT, 2'd0);
        // Reset in the middle of a line with ENABLE held high
        run(HT + 7, 2'd3);
        step(1'b1, 1'b1, 2'd3);
        step(1'b1, 1'b1, 2'd3);
        run(FT + 20, 2'd3);
        // ENABLE low for 50 cycles mid-line
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 2'd1);
        run(FT + HT, 2'd1);
        ps = 2'd1;
        for (int unsigned i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 6) ps = 2'($urandom_range(0, 3));
            if (r == 7) begin
                for (int unsigned k = $urandom_range(1, 40); k > 0; k--) step(1'b0, 1'b0, ps);
            end else if (r == 8) begin
                for (int unsigned k = $urandom_range(1, 3); k > 0; k--) step(1'b1, 1'b1, ps);
            end else begin
                step(1'b0, 1'b1, ps);
            end
        end
        @(posedge CLK);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
